// File: rtl/alu_ctrl_seq_pkg.sv
// Shared constants for the registered ALU control decoder: control codes,
// funct encodings, mul/div sequencer state and the decode result record.
package alu_ctrl_seq_pkg;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_SLL   = 5'd1;
  localparam logic [4:0] ALU_SRL   = 5'd2;
  localparam logic [4:0] ALU_SRA   = 5'd3;
  localparam logic [4:0] ALU_SLLV  = 5'd4;
  localparam logic [4:0] ALU_SRLV  = 5'd5;
  localparam logic [4:0] ALU_SRAV  = 5'd6;
  localparam logic [4:0] ALU_LUI   = 5'd7;
  localparam logic [4:0] ALU_ADD   = 5'd8;
  localparam logic [4:0] ALU_SUB   = 5'd9;
  localparam logic [4:0] ALU_AND   = 5'd10;
  localparam logic [4:0] ALU_OR    = 5'd11;
  localparam logic [4:0] ALU_XOR   = 5'd12;
  localparam logic [4:0] ALU_NOR   = 5'd13;
  localparam logic [4:0] ALU_SLT   = 5'd14;
  localparam logic [4:0] ALU_SLTU  = 5'd15;
  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MFHI  = 5'd20;
  localparam logic [4:0] ALU_MFLO  = 5'd21;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_t;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       jr;
    logic       illegal;
  } decode_t;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_div_funct(input logic [5:0] f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response and mul/div status bundle between the ID/EX stage,
// the ALU control decoder and the ALU / mul-div unit.
interface alu_ctrl_seq_if #(
  parameter int OP_W   = 3,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   alu_op;
  logic [5:0]        funct;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              jr_ctrl;
  logic              illegal;
  logic              md_start;
  logic              md_busy;
  logic              md_done;

  modport master (
    output in_valid, alu_op, funct, out_ready,
    input  in_ready, out_valid, alu_ctrl, jr_ctrl, illegal,
           md_start, md_busy, md_done
  );

  modport slave (
    input  in_valid, alu_op, funct, out_ready,
    output in_ready, out_valid, alu_ctrl, jr_ctrl, illegal,
           md_start, md_busy, md_done
  );
endinterface

// File: rtl/alu_ctrl_seq_md_sequencer.sv
// Mul/div latency sequencer: IDLE/RUN FSM with a down-counter that ends the
// operation at terminal count zero.
//   state   | meaning
//   MD_IDLE | no mul/div in flight, counter parked at 0
//   MD_RUN  | mul/div in flight; cnt==0 marks the md_done cycle
module alu_ctrl_seq_md_sequencer
  import alu_ctrl_seq_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic md_start,
  output logic busy,
  output logic done
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start && (state_q == MD_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_RUN;
          cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) state_d = MD_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_start = start_q;
  assign busy     = (state_q == MD_RUN);
  assign done     = busy && (cnt_q == '0);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode with valid/ready output stage, mul/div
// launch sequencing and a HI/LO interlock for mfhi/mflo.
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  function automatic decode_t decode(input logic [OP_W-1:0] op, input logic [5:0] f);
    decode_t d;
    int      op_i;
    d    = '0;
    op_i = int'(op);
    case (op_i)
      0: begin
        case (f)
          F_SLL:   d.ctrl = ALU_SLL;
          F_SRL:   d.ctrl = ALU_SRL;
          F_SRA:   d.ctrl = ALU_SRA;
          F_SLLV:  d.ctrl = ALU_SLLV;
          F_SRLV:  d.ctrl = ALU_SRLV;
          F_SRAV:  d.ctrl = ALU_SRAV;
          F_ADD:   d.ctrl = ALU_ADD;
          F_SUB:   d.ctrl = ALU_SUB;
          F_AND:   d.ctrl = ALU_AND;
          F_OR:    d.ctrl = ALU_OR;
          F_XOR:   d.ctrl = ALU_XOR;
          F_NOR:   d.ctrl = ALU_NOR;
          F_SLT:   d.ctrl = ALU_SLT;
          F_SLTU:  d.ctrl = ALU_SLTU;
          F_MULT:  d.ctrl = ALU_MULT;
          F_MULTU: d.ctrl = ALU_MULTU;
          F_DIV:   d.ctrl = ALU_DIV;
          F_DIVU:  d.ctrl = ALU_DIVU;
          F_MFHI:  d.ctrl = ALU_MFHI;
          F_MFLO:  d.ctrl = ALU_MFLO;
          F_JR:    d.jr   = 1'b1;
          default: d.illegal = 1'b1;
        endcase
      end
      1:       d.ctrl = ALU_LUI;
      2:       d.ctrl = ALU_SLT;
      3:       d.ctrl = ALU_ADD;
      4:       d.ctrl = ALU_SLTU;
      5:       d.ctrl = ALU_AND;
      6:       d.ctrl = ALU_OR;
      7:       d.ctrl = ALU_XOR;
      default: d.ctrl = ALU_NOP;
    endcase
    return d;
  endfunction

  decode_t           dec;
  logic              is_rtype;
  logic              req_md;
  logic              req_md_or_hilo;
  logic              accept;
  logic              md_busy;
  logic              md_done;
  logic              md_start;
  logic              out_valid_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              jr_q;
  logic              illegal_q;

  assign dec            = decode(bus.alu_op, bus.funct);
  assign is_rtype       = (bus.alu_op == '0);
  assign req_md         = is_rtype && is_md_funct(bus.funct);
  assign req_md_or_hilo = is_rtype && (is_md_funct(bus.funct) || is_hilo_funct(bus.funct));

  // HI/LO consumers and new mul/div wait out the whole RUN, md_done cycle included.
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !(md_busy && req_md_or_hilo);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      jr_q        <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      alu_ctrl_q  <= CTRL_W'(dec.ctrl);
      jr_q        <= dec.jr;
      illegal_q   <= dec.illegal;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  alu_ctrl_seq_md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && req_md),
    .is_div   (is_div_funct(bus.funct)),
    .md_start (md_start),
    .busy     (md_busy),
    .done     (md_done)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.jr_ctrl   = jr_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_start  = md_start;
  assign bus.md_busy   = md_busy;
  assign bus.md_done   = md_done;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq: decode, backpressure,
// mul/div sequencing, HI/LO interlock and asynchronous reset abort.
module tb_alu_ctrl_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_ctrl_seq_if #(.OP_W(3), .CTRL_W(5)) bus ();

  alu_ctrl_seq #(
    .OP_W    (3),
    .CTRL_W  (5),
    .MUL_LAT (4),
    .DIV_LAT (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.funct    = f;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.alu_ctrl !== 5'd0 || bus.jr_ctrl !== 1'b0 ||
        bus.illegal !== 1'b0 || bus.md_start !== 1'b0 || bus.md_busy !== 1'b0 ||
        bus.md_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ctrl=%0d jr=%b ill=%b st=%b busy=%b done=%b, want all 0",
               bus.out_valid, bus.alu_ctrl, bus.jr_ctrl, bus.illegal, bus.md_start, bus.md_busy, bus.md_done);
    end
  endtask

  task automatic test_decode_basic();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 6'h20);
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd8 || bus.jr_ctrl !== 1'b0 || bus.illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL add_decode: got valid=%b ctrl=%0d jr=%b ill=%b want 1/8/0/0",
               bus.out_valid, bus.alu_ctrl, bus.jr_ctrl, bus.illegal);
    end
    drive(1'b1, 3'd0, 6'h08);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd0 || bus.jr_ctrl !== 1'b1 || bus.illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL jr_decode: got valid=%b ctrl=%0d jr=%b ill=%b want 1/0/1/0",
               bus.out_valid, bus.alu_ctrl, bus.jr_ctrl, bus.illegal);
    end
    drive(1'b0, 3'd0, 6'h00);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_valid: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 6'h22);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd9) begin
      n_fail++; $display("FAIL sub_load: got valid=%b ctrl=%0d want 1/9", bus.out_valid, bus.alu_ctrl);
    end
    drive(1'b1, 3'd0, 6'h20);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd9) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b ctrl=%0d want 1/9", i, bus.out_valid, bus.alu_ctrl);
      end
    end
    bus.out_ready = 1'b1;
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd8) begin
      n_fail++; $display("FAIL bp_next: got valid=%b ctrl=%0d want 1/8", bus.out_valid, bus.alu_ctrl);
    end
    drive(1'b0, 3'd0, 6'h00);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] f_tab [6];
    logic [4:0] e_tab [6];
    f_tab = '{6'h00, 6'h07, 6'h27, 6'h2B, 6'h10, 6'h03};
    e_tab = '{5'd1, 5'd6, 5'd13, 5'd15, 5'd20, 5'd3};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'd0, f_tab[k]);
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== e_tab[k] || bus.illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b[%0d]: funct=%h got valid=%b ctrl=%0d ill=%b want 1/%0d/0",
                 k, f_tab[k], bus.out_valid, bus.alu_ctrl, bus.illegal, e_tab[k]);
      end
    end
    drive(1'b0, 3'd0, 6'h00);
    tick();
  endtask

  task automatic test_mult();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 6'h18);
    tick();
    n_checks++;
    if (bus.alu_ctrl !== 5'd16 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mult_decode: got valid=%b ctrl=%0d want 1/16", bus.out_valid, bus.alu_ctrl);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, 3'd0, 6'h20);
      else        drive(1'b0, 3'd0, 6'h00);
      #2;
      n_checks++;
      if (bus.md_start !== (i == 0) || bus.md_busy !== (i < 4) || bus.md_done !== (i == 3)) begin
        n_fail++;
        $display("FAIL mult_seq[%0d]: got start=%b busy=%b done=%b want %b/%b/%b",
                 i, bus.md_start, bus.md_busy, bus.md_done, (i == 0), (i < 4), (i == 3));
      end
      if (i == 0) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL add_during_busy_ready: got %b want 1", bus.in_ready);
        end
      end
      tick();
      if (i == 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd8) begin
          n_fail++; $display("FAIL add_during_busy: got valid=%b ctrl=%0d want 1/8", bus.out_valid, bus.alu_ctrl);
        end
      end
    end
  endtask

  task automatic test_div_hilo();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 6'h1A);
    tick();
    drive(1'b1, 3'd0, 6'h12);
    for (int i = 0; i < 32; i++) begin
      #2;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.md_busy !== 1'b1 || bus.md_done !== (i == 31)) begin
        n_fail++;
        $display("FAIL div_stall[%0d]: got ready=%b busy=%b done=%b want 0/1/%b",
                 i, bus.in_ready, bus.md_busy, bus.md_done, (i == 31));
      end
      tick();
    end
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.md_busy !== 1'b0 || bus.md_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mflo_release: got ready=%b busy=%b done=%b want 1/0/0", bus.in_ready, bus.md_busy, bus.md_done);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd21) begin
      n_fail++; $display("FAIL mflo_accept: got valid=%b ctrl=%0d want 1/21", bus.out_valid, bus.alu_ctrl);
    end
    drive(1'b0, 3'd0, 6'h00);
    tick();
  endtask

  task automatic test_itype_sweep();
    logic [4:0] e_tab [7];
    logic [5:0] f;
    e_tab = '{5'd7, 5'd14, 5'd8, 5'd15, 5'd10, 5'd11, 5'd12};
    bus.out_ready = 1'b1;
    for (int op = 1; op <= 7; op++) begin
      f = 6'($urandom_range(0, 63));
      drive(1'b1, 3'(op), f);
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== e_tab[op-1] || bus.illegal !== 1'b0 || bus.jr_ctrl !== 1'b0) begin
        n_fail++;
        $display("FAIL itype[%0d]: funct=%h got valid=%b ctrl=%0d ill=%b jr=%b want 1/%0d/0/0",
                 op, f, bus.out_valid, bus.alu_ctrl, bus.illegal, bus.jr_ctrl, e_tab[op-1]);
      end
    end
    drive(1'b1, 3'd0, 6'h3F);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 5'd0 || bus.illegal !== 1'b1 || bus.jr_ctrl !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_3f: got valid=%b ctrl=%0d ill=%b jr=%b want 1/0/1/0",
               bus.out_valid, bus.alu_ctrl, bus.illegal, bus.jr_ctrl);
    end
    drive(1'b0, 3'd0, 6'h00);
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 6'h1B);
    tick();
    drive(1'b0, 3'd0, 6'h00);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.alu_ctrl !== 5'd0 || bus.md_busy !== 1'b0 ||
        bus.md_start !== 1'b0 || bus.md_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b ctrl=%0d busy=%b st=%b done=%b want all 0",
               bus.out_valid, bus.alu_ctrl, bus.md_busy, bus.md_start, bus.md_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.md_done !== 1'b0 || bus.md_busy !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL no_done_after_reset: got activity=%b want 0", saw_done);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 6'h00);
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_decode_basic();
    test_backpressure();
    test_back_to_back();
    test_mult();
    test_div_hilo();
    test_itype_sweep();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
